// File: rtl/xor_pkg.sv
// Shared definitions for the xor_unit_n stream engine.
// Holds the operating-mode encoding carried with every accepted word.
package xor_pkg;

  typedef enum logic [1:0] {
    XOR_BITWISE = 2'b00,
    XOR_ACCUM   = 2'b01,
    XOR_PARITY  = 2'b10,
    XOR_LOAD    = 2'b11
  } xor_mode_e;

endpackage

// File: rtl/xor_unit_n.sv
// WIDTH-bit XOR stream engine: bitwise XOR, running checksum, parity and load.
// Uses valid/ready on both sides, with one registered output stage.
module xor_unit_n
  import xor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  xor_mode_e        mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clear_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             parity_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;

  // The stage can take a word when it is empty or is being drained this cycle.
  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;
  assign x       = a_i ^ b_i;

  // Clear acts before the accepted word is folded in.
  assign acc_base = clear_i ? '0 : acc_q;
  assign cnt_base = clear_i ? '0 : cnt_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    valid_d  = valid_q;
    s_d      = s_q;
    parity_d = parity_q;
    acc_d    = acc_base;
    cnt_d    = cnt_base;

    if (accept) begin
      valid_d = 1'b1;
      unique case (mode_i)
        XOR_BITWISE: s_d = x;
        XOR_ACCUM: begin
          acc_d = acc_base ^ x;
          s_d   = acc_base ^ x;
          cnt_d = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
        end
        XOR_PARITY: begin
          s_d    = '0;
          s_d[0] = ^x;
        end
        XOR_LOAD: begin
          acc_d = x;
          s_d   = x;
          cnt_d = CNT_W'(1);
        end
      endcase
      parity_d = ^s_d;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      s_q      <= '0;
      parity_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      s_q      <= s_d;
      parity_q <= parity_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o  = valid_q;
  assign s_o      = s_q;
  assign parity_o = parity_q;
  assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_xor_unit_n.sv
// Self-checking bench for xor_unit_n: directed scenarios plus randomized traffic
// against a word-level reference model; two instances differ only in counter width.
module tb_xor_unit_n;
  import xor_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i, valid_i, clear_i, ready_i;
  xor_mode_e  mode_i;
  logic [3:0] a_i, b_i;

  logic       ready_a, valid_a, parity_a;
  logic [3:0] s_a;
  logic [7:0] cnt_a;
  logic       ready_b, valid_b, parity_b;
  logic [3:0] s_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit       m_valid;
  bit [3:0] m_s;
  bit       m_par;
  bit [3:0] m_acc;
  int       m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  xor_unit_n #(.WIDTH(4), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_a),
    .mode_i(mode_i), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .valid_o(valid_a), .ready_i(ready_i), .s_o(s_a), .parity_o(parity_a),
    .cnt_o(cnt_a)
  );

  xor_unit_n #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_b),
    .mode_i(mode_i), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .valid_o(valid_b), .ready_i(ready_i), .s_o(s_b), .parity_o(parity_b),
    .cnt_o(cnt_b)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
  endtask

  // One clock: drive at the falling edge, advance the model, compare after the rising edge.
  task automatic step(input bit rst, input bit v, input xor_mode_e m,
                      input bit [3:0] a, input bit [3:0] b,
                      input bit clr, input bit rdy);
    bit       m_ready, acc_in;
    bit [3:0] x;
    rst_i = rst; valid_i = v; mode_i = m; a_i = a; b_i = b;
    clear_i = clr; ready_i = rdy;
    #1;
    m_ready = !m_valid || rdy;
    if (!rst) begin
      check("ready_a", int'(ready_a), int'(m_ready));
      check("ready_b", int'(ready_b), int'(m_ready));
    end

    if (rst) begin
      m_valid = 0; m_s = 0; m_par = 0; m_acc = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (clr) begin
        m_acc = 0; m_cnt8 = 0; m_cnt2 = 0;
      end
      acc_in = v && m_ready;
      if (acc_in) begin
        x = a ^ b;
        case (int'(m))
          0: m_s = x;
          1: begin
            m_acc  = m_acc ^ x;
            m_s    = m_acc;
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
          end
          2: m_s = 4'($countones(x) % 2);
          default: begin
            m_acc = x; m_s = x; m_cnt8 = 1; m_cnt2 = 1;
          end
        endcase
        m_par   = bit'($countones(m_s) % 2);
        m_valid = 1;
      end else if (rdy) begin
        m_valid = 0;
      end
    end

    @(posedge clk);
    #1;
    check("valid_a",  int'(valid_a),  int'(m_valid));
    check("s_a",      int'(s_a),      int'(m_s));
    check("parity_a", int'(parity_a), int'(m_par));
    check("cnt_a",    int'(cnt_a),    m_cnt8);
    check("valid_b",  int'(valid_b),  int'(m_valid));
    check("s_b",      int'(s_b),      int'(m_s));
    check("cnt_b",    int'(cnt_b),    m_cnt2);
    @(negedge clk);
  endtask

  initial begin
    int cnt2_exp[5] = '{1, 2, 3, 3, 3};
    bit [3:0] seq_s[3] = '{4'h3, 4'h6, 4'h9};
    @(negedge clk);

    // reset for two cycles
    step(1, 0, XOR_BITWISE, 0, 0, 0, 1);
    step(1, 0, XOR_BITWISE, 0, 0, 0, 1);
    rst_i = 0; valid_i = 0; ready_i = 1; clear_i = 0; #1;
    check("t1_valid", int'(valid_a), 0);
    check("t1_s",     int'(s_a), 0);
    check("t1_cnt",   int'(cnt_a), 0);
    check("t1_ready", int'(ready_a), 1);

    // bitwise
    step(0, 1, XOR_BITWISE, 4'b1010, 4'b0110, 0, 1);
    check("t2_s",   int'(s_a), 12);
    check("t2_par", int'(parity_a), 0);
    check("t2_cnt", int'(cnt_a), 0);

    // accumulate back-to-back
    for (int i = 0; i < 3; i++) begin
      bit [3:0] av[3] = '{4'h3, 4'h5, 4'hF};
      step(0, 1, XOR_ACCUM, av[i], 0, 0, 1);
      check("t3_s",   int'(s_a), int'(seq_s[i]));
      check("t3_cnt", int'(cnt_a), i + 1);
    end

    // backpressure: output held, no accept
    for (int i = 0; i < 3; i++) begin
      step(0, 1, XOR_ACCUM, 4'h1, 0, 0, 0);
      check("t4_ready", int'(ready_a), 0);
      check("t4_hold",  int'(s_a), 9);
    end
    step(0, 1, XOR_ACCUM, 4'h1, 0, 0, 1);
    check("t4_s",   int'(s_a), 8);
    check("t4_cnt", int'(cnt_a), 4);

    // clear with accumulate, load, parity
    step(0, 1, XOR_ACCUM, 4'h2, 0, 0, 1);
    check("t5_acc", int'(s_a), 10);
    step(0, 1, XOR_ACCUM, 4'h7, 0, 1, 1);
    check("t5_clr_s",   int'(s_a), 7);
    check("t5_clr_cnt", int'(cnt_a), 1);
    step(0, 1, XOR_LOAD, 4'hC, 4'h3, 0, 1);
    check("t5_load_s",   int'(s_a), 15);
    check("t5_load_cnt", int'(cnt_a), 1);
    step(0, 1, XOR_PARITY, 4'b0111, 0, 0, 1);
    check("t5_par_s", int'(s_a), 1);

    // counter saturation on the narrow instance
    step(0, 0, XOR_BITWISE, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, XOR_ACCUM, 4'(i + 1), 0, 0, 1);
      check("t6_cnt", int'(cnt_b), cnt2_exp[i]);
    end
    check("t6_valid_pre", int'(valid_b), 1);
    step(1, 1, XOR_ACCUM, 4'h5, 0, 0, 0);
    check("t6_rst_valid", int'(valid_b), 0);
    check("t6_rst_cnt",   int'(cnt_b), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0,
           xor_mode_e'($urandom_range(0, 3)),
           4'($urandom), 4'($urandom),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
